// File: rtl/fpu_ss_wb_arbiter.sv
// Arbitrates FP register file writes between FPU results and buffered load
// responses. Loads have priority until the FPU has been stalled STARVE_LIMIT cycles.
module fpu_ss_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int MEM_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fpu_valid_i,
    output logic              fpu_ready_o,
    input  logic [ADDR_W-1:0] fpu_addr_i,
    input  logic [DATA_W-1:0] fpu_data_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              fpr_we_o,
    output logic [ADDR_W-1:0] fpr_waddr_o,
    output logic [DATA_W-1:0] fpr_wdata_o,
    output logic              mem_overflow_o,
    output logic              mem_pending_o
);

    localparam int CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MEM_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MEM_DEPTH - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] fifo_addr_q [MEM_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [MEM_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              overflow_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic fifo_empty, fifo_full, starved;
    logic grant_mem, grant_fpu, push, pop, drop;

    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == DEPTH_C);
        starved     = (starve_q == STV_MAX);
        fpu_ready_o = fifo_empty | starved;
        grant_mem   = ~fifo_empty & ~starved;
        grant_fpu   = fpu_valid_i & fpu_ready_o;
        pop         = grant_mem;
        push        = mem_valid_i & (~fifo_full | pop);
        drop        = mem_valid_i & fifo_full & ~pop;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        starve_d = '0;
        if (fpu_valid_i && !fpu_ready_o)
            starve_d = starved ? starve_q : starve_q + 1'b1;
    end

    // Storage is not reset: validity is tracked solely by count/pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mem_addr_i;
            fifo_data_q[wr_ptr_q] <= mem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Registered write port; address/data hold their last value when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= grant_mem | grant_fpu;
            if (grant_mem) begin
                waddr_q <= fifo_addr_q[rd_ptr_q];
                wdata_q <= fifo_data_q[rd_ptr_q];
            end else if (grant_fpu) begin
                waddr_q <= fpu_addr_i;
                wdata_q <= fpu_data_i;
            end
        end
    end

    assign fpr_we_o       = we_q;
    assign fpr_waddr_o    = waddr_q;
    assign fpr_wdata_o    = wdata_q;
    assign mem_overflow_o = overflow_q;
    assign mem_pending_o  = (count_q != '0);

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed self-checking bench for fpu_ss_wb_arbiter with default parameters
// (MEM_DEPTH=2, STARVE_LIMIT=4); expected values are hand-derived tables.
module tb_fpu_ss_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [4:0]  fpu_addr_i;
    logic [31:0] fpu_data_i;
    logic        mem_valid_i;
    logic [4:0]  mem_addr_i;
    logic [31:0] mem_data_i;
    logic        fpr_we_o;
    logic [4:0]  fpr_waddr_o;
    logic [31:0] fpr_wdata_o;
    logic        mem_overflow_o;
    logic        mem_pending_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [4:0]  FPU_ADDR = 5'd20;
    localparam logic [31:0] FPU_DATA = 32'h4049_0FDB;

    // Write code per cycle: -1 none, 99 FPU result, otherwise load index i
    // (load i carries addr 8+i, data 0xA000_0000+i). Loads 0..10 and FPU
    // valid are driven on cycles 0..10; load 10 hits a full FIFO during a
    // forced FPU grant and is dropped.
    int exp_wr   [16] = '{-1, 99, 0, 1, 2, 3, 99, 4, 5, 6, 7, 99, 8, 9, -1, -1};
    bit exp_rdy  [16] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
    bit exp_pend [16] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit exp_ovf  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    fpu_ss_wb_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fpu_valid_i    (fpu_valid_i),
        .fpu_ready_o    (fpu_ready_o),
        .fpu_addr_i     (fpu_addr_i),
        .fpu_data_i     (fpu_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .fpr_we_o       (fpr_we_o),
        .fpr_waddr_o    (fpr_waddr_o),
        .fpr_wdata_o    (fpr_wdata_o),
        .mem_overflow_o (mem_overflow_o),
        .mem_pending_o  (mem_pending_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        fpu_valid_i = 1'b0;
        fpu_addr_i  = '0;
        fpu_data_i  = '0;
        mem_valid_i = 1'b0;
        mem_addr_i  = '0;
        mem_data_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic check_write(input string tag, input int code);
        check({tag, "_we"}, 64'(fpr_we_o), 64'(code != -1));
        if (code == 99) begin
            check({tag, "_waddr"}, 64'(fpr_waddr_o), 64'(FPU_ADDR));
            check({tag, "_wdata"}, 64'(fpr_wdata_o), 64'(FPU_DATA));
        end else if (code >= 0) begin
            check({tag, "_waddr"}, 64'(fpr_waddr_o), 64'(8 + code));
            check({tag, "_wdata"}, 64'(fpr_wdata_o), 64'(32'hA000_0000 + code));
        end
    endtask

    task automatic run_table(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            fpu_valid_i = (k <= 10);
            fpu_addr_i  = FPU_ADDR;
            fpu_data_i  = FPU_DATA;
            mem_valid_i = (k <= 10);
            mem_addr_i  = 5'(8 + k);
            mem_data_i  = 32'hA000_0000 + 32'(k);
            #1;
            check($sformatf("tbl%0d_ready", k), 64'(fpu_ready_o), 64'(exp_rdy[k]));
            check($sformatf("tbl%0d_pend", k), 64'(mem_pending_o), 64'(exp_pend[k]));
            check($sformatf("tbl%0d_ovf", k), 64'(mem_overflow_o), 64'(exp_ovf[k]));
            check_write($sformatf("tbl%0d", k), exp_wr[k]);
        end
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #3;
        check("rst_we", 64'(fpr_we_o), 64'd0);
        check("rst_waddr", 64'(fpr_waddr_o), 64'd0);
        check("rst_wdata", 64'(fpr_wdata_o), 64'd0);
        check("rst_ovf", 64'(mem_overflow_o), 64'd0);
        check("rst_pend", 64'(mem_pending_o), 64'd0);
        check("rst_ready", 64'(fpu_ready_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // FPU result with idle FIFO: accepted at once, written next cycle
        step();
        fpu_valid_i = 1'b1; fpu_addr_i = 5'd3; fpu_data_i = 32'h3F80_0000;
        #1;
        check("fpu_ready", 64'(fpu_ready_o), 64'd1);
        step();
        fpu_valid_i = 1'b0;
        #1;
        check("fpu_we", 64'(fpr_we_o), 64'd1);
        check("fpu_waddr", 64'(fpr_waddr_o), 64'd3);
        check("fpu_wdata", 64'(fpr_wdata_o), 64'h3F80_0000);
        step();
        check("fpu_we_off", 64'(fpr_we_o), 64'd0);
        check("fpu_waddr_hold", 64'(fpr_waddr_o), 64'd3);

        // Load response: pending next cycle, written two cycles later
        step();
        mem_valid_i = 1'b1; mem_addr_i = 5'd7; mem_data_i = 32'hDEAD_BEEF;
        #1;
        check("ld_pend0", 64'(mem_pending_o), 64'd0);
        step();
        mem_valid_i = 1'b0;
        #1;
        check("ld_pend1", 64'(mem_pending_o), 64'd1);
        check("ld_we1", 64'(fpr_we_o), 64'd0);
        step();
        check("ld_we2", 64'(fpr_we_o), 64'd1);
        check("ld_waddr2", 64'(fpr_waddr_o), 64'd7);
        check("ld_wdata2", 64'(fpr_wdata_o), 64'hDEAD_BEEF);
        check("ld_pend2", 64'(mem_pending_o), 64'd0);

        // Starvation, forced FPU grants, full FIFO push+pop with wrap, drop
        run_table(16);

        // Reset mid-operation with two entries queued
        do_reset();
        run_table(7);
        #2 rst_ni = 1'b0;
        #1;
        check("mrst_we", 64'(fpr_we_o), 64'd0);
        check("mrst_waddr", 64'(fpr_waddr_o), 64'd0);
        check("mrst_wdata", 64'(fpr_wdata_o), 64'd0);
        check("mrst_pend", 64'(mem_pending_o), 64'd0);
        check("mrst_ovf", 64'(mem_overflow_o), 64'd0);
        idle_inputs();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst%0d_we", i), 64'(fpr_we_o), 64'd0);
            check($sformatf("post_rst%0d_pend", i), 64'(mem_pending_o), 64'd0);
        end
        fpu_valid_i = 1'b1; fpu_addr_i = 5'd9; fpu_data_i = 32'h1234_5678;
        step();
        fpu_valid_i = 1'b0;
        #1;
        check("post_rst_fpu_we", 64'(fpr_we_o), 64'd1);
        check("post_rst_fpu_waddr", 64'(fpr_waddr_o), 64'd9);
        check("post_rst_fpu_wdata", 64'(fpr_wdata_o), 64'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
